// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 op codes, the M-extension funct7 marker, FSM states and operand signedness helpers.
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  function automatic logic signedA(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic signedB(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide sequencer (slave).
interface muldiv_seq_if #(
  parameter int XLEN = 32
);

  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            stall_o;
  logic            busy_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  modport master (
    output start_i, flush_i, funct3_i, op_a_i, op_b_i,
    input  stall_o, busy_o, result_o, result_valid_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, op_a_i, op_b_i,
    output stall_o, busy_o, result_o, result_valid_o
  );

endinterface

// File: rtl/muldiv_dp.sv
// Datapath of the sequencer: latched operand magnitudes, the shared shift-add / restoring-divide
// accumulator, divide special-case detection and the final sign fixup into the result register.
module muldiv_dp
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3In,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            isSpecial,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        f3Reg;
  logic              negA;
  logic              negB;
  logic [XLEN-1:0]   magB;
  logic [2*XLEN-1:0] acc;

  logic              negAIn;
  logic              negBIn;
  logic [XLEN-1:0]   magAIn;
  logic [XLEN-1:0]   magBIn;
  logic              divByZero;
  logic              overflow;
  logic [XLEN-1:0]   specialResult;

  logic [2*XLEN:0]   shifted;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     sumHi;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   fixed;

  // Operand magnitudes and the divide corner cases that bypass iteration entirely.
  always_comb begin
    negAIn    = signedA(funct3In) & opA[XLEN-1];
    negBIn    = signedB(funct3In) & opB[XLEN-1];
    magAIn    = negAIn ? -opA : opA;
    magBIn    = negBIn ? -opB : opB;
    divByZero = funct3In[2] & (opB == '0);
    overflow  = ((funct3In == DIV) || (funct3In == REM)) & (opA == MIN_NEG) & (opB == '1);
    isSpecial = divByZero | overflow;
    if (divByZero) begin
      specialResult = funct3In[1] ? opA : '1;
    end else begin
      specialResult = funct3In[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration: the low half holds the multiplier or quotient, the high half the partial sum or remainder.
  always_comb begin
    shifted = {acc, 1'b0};
    trial   = shifted[2*XLEN:XLEN] - {1'b0, magB};
    sumHi   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, magB} : '0);
    accNext = acc;
    if (f3Reg[2]) begin
      if (!trial[XLEN]) begin
        accNext = {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
      end else begin
        accNext = shifted[2*XLEN-1:0];
      end
    end else begin
      accNext = {sumHi, acc[XLEN-1:1]};
    end
  end

  // Sign fixup is taken from accNext so the last iteration and the result write share a cycle.
  always_comb begin
    product   = (negA ^ negB) ? -accNext : accNext;
    quotient  = (negA ^ negB) ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
    remainder = negA ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
    case (f3Reg)
      MUL:                 fixed = product[XLEN-1:0];
      MULH, MULHSU, MULHU: fixed = product[2*XLEN-1:XLEN];
      DIV, DIVU:           fixed = quotient;
      default:             fixed = remainder;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3Reg  <= '0;
      negA   <= 1'b0;
      negB   <= 1'b0;
      magB   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        f3Reg <= funct3In;
        negA  <= negAIn;
        negB  <= negBIn;
        magB  <= magBIn;
        acc   <= {{XLEN{1'b0}}, magAIn};
        if (isSpecial) begin
          result <= specialResult;
        end
      end
      if (step) begin
        acc <= accNext;
      end
      if (finish) begin
        result <= fixed;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: the FSM, iteration counter and
// pipeline stall live here; the arithmetic is in muldiv_dp.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);

  stateT            state;
  logic [CNT_W-1:0] counter;
  logic             resultValid;
  logic             accept;
  logic             isSpecial;
  logic             lastIter;
  logic             dpStep;
  logic             dpFinish;

  // The start cycle must stall combinationally, otherwise the instruction would slip past EX.
  always_comb begin
    accept   = (state == IDLE) & bus.start_i & ~bus.flush_i;
    lastIter = (counter == CNT_W'(XLEN - 1));
    dpStep   = (state == RUN) & ~bus.flush_i;
    dpFinish = dpStep & lastIter;
  end

  assign bus.stall_o        = accept | (state == RUN);
  assign bus.busy_o         = (state != IDLE);
  assign bus.result_valid_o = resultValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      resultValid <= 1'b0;
    end else begin
      resultValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            counter <= '0;
            if (isSpecial) begin
              state       <= DONE;
              resultValid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (lastIter) begin
            state       <= DONE;
            resultValid <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  muldiv_dp #(
    .XLEN(XLEN)
  ) dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (dpStep),
    .finish    (dpFinish),
    .funct3In  (bus.funct3_i),
    .opA       (bus.op_a_i),
    .opB       (bus.op_b_i),
    .isSpecial (isSpecial),
    .result    (bus.result_o)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a plain-arithmetic RV32M model plus a latency/holding model
// checked every cycle, with hand-computed literals for each directed operation.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  logic        checkEn   = 1'b0;
  logic        expStall  = 1'b0;
  logic        expBusy   = 1'b0;
  logic        expValid  = 1'b0;
  logic [31:0] expResult = '0;
  logic [31:0] lastResult = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // RV32M result computed with ordinary 64-bit / signed arithmetic.
  function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      ub;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f3)
      MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      MULH:   begin p = sa * sb;                 return p[63:32]; end
      MULHSU: begin p = sa * ub;                 return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic isShortcut(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || ((f3 == DIV || f3 == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", {31'b0, bus.stall_o}, {31'b0, expStall});
      checkOutput("busy", {31'b0, bus.busy_o}, {31'b0, expBusy});
      checkOutput("valid", {31'b0, bus.result_valid_o}, {31'b0, expValid});
      checkOutput("result", bus.result_o, expResult);
    end
  end

  task automatic applyStimulus(input logic start, input logic flush, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b);
    bus.start_i  = start;
    bus.flush_i  = flush;
    bus.funct3_i = f3;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
  endtask

  task automatic setExpect(input logic s, input logic bz, input logic v, input logic [31:0] r);
    expStall  = s;
    expBusy   = bz;
    expValid  = v;
    expResult = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, MUL, $urandom, $urandom);
      setExpect(1'b0, 1'b0, 1'b0, lastResult);
      nextCycle();
    end
  endtask

  // One instruction held in EX until its result pulse; operands are scrambled after capture.
  task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
    logic [31:0] exp;
    int          lat;
    int          stallCycles;
    int          validAt;
    exp         = modelResult(f3, a, b);
    lat         = isShortcut(f3, a, b) ? 1 : 33;
    stallCycles = 0;
    validAt     = -1;
    for (int k = 0; k <= lat; k++) begin
      if (k == 0) applyStimulus(1'b1, 1'b0, f3, a, b);
      else        applyStimulus(1'b1, 1'b0, f3, $urandom, $urandom);
      setExpect(k < lat, k >= 1, k == lat, (k == lat) ? exp : lastResult);
      @(negedge clk);
      if (bus.stall_o) stallCycles++;
      if (bus.result_valid_o && validAt < 0) validAt = k;
      if (k == lat) checkOutput({name, " literal"}, bus.result_o, lit);
      nextCycle();
    end
    lastResult = exp;
    checkOutput({name, " stallCycles"}, stallCycles, lat);
    checkOutput({name, " validCycle"}, validAt, lat);
    idleCycles(2);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, MUL, '0, '0);
    setExpect(1'b0, 1'b0, 1'b0, 32'h0);
    checkEn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nextCycle();
    rst_n = 1'b1;
    idleCycles(2);

    runOp("MUL 7*-3", MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    runOp("MULHU max*max", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("MULH min*min", MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    runOp("MULHSU min*max", MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    runOp("DIV -7/2", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    runOp("REM -7/2", REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    runOp("DIVU 100/0", DIVU, 32'd100, 32'd0, 32'hFFFFFFFF);
    runOp("REMU 100/0", REMU, 32'd100, 32'd0, 32'd100);
    runOp("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    runOp("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    runOp("REMU 1000/7", REMU, 32'd1000, 32'd7, 32'd6);

    // Flush in the middle of a divide: no result pulse, even past its natural completion.
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) applyStimulus(1'b1, 1'b0, DIVU, 32'd1000, 32'd7);
      else        applyStimulus(1'b1, k == 10, DIVU, $urandom, $urandom);
      setExpect(1'b1, k >= 1, 1'b0, lastResult);
      nextCycle();
    end
    idleCycles(40);
    runOp("DIVU after flush", DIVU, 32'd1000, 32'd7, 32'd142);

    // Asynchronous reset part-way through a multiply.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) applyStimulus(1'b1, 1'b0, MUL, 32'd5, 32'd6);
      else        applyStimulus(1'b1, 1'b0, MUL, $urandom, $urandom);
      setExpect(1'b1, k >= 1, 1'b0, lastResult);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, MUL, $urandom, $urandom);
    #2;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    lastResult  = 32'h0;
    setExpect(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rst stall", {31'b0, bus.stall_o}, 32'h0);
    checkOutput("rst busy", {31'b0, bus.busy_o}, 32'h0);
    checkOutput("rst valid", {31'b0, bus.result_valid_o}, 32'h0);
    checkOutput("rst result", bus.result_o, 32'h0);
    @(negedge clk);
    nextCycle();
    rst_n = 1'b1;
    idleCycles(2);
    runOp("MULHSU -1*2", MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer attached to the EX stage of the 5-stage pipeline.
- The decode stage flags M-extension instructions: ALUreg opcode with funct7 = 0000001.
- In EX, this block captures the operands and runs a one-bit-per-cycle shift-add multiply or restoring divide.
- It stalls the IF/ID/EX stages until the result is ready, then hands the result to the EX/MEM register.

Parameters:
XLEN, 32, operand and result width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  pipeline clock.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  an M-extension instruction is valid in EX; held high while stalled.
flush_i  in  1  EX flush (branch or jump redirect); aborts the current operation.
funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a_i  in  XLEN  rs1 value after forwarding.
op_b_i  in  XLEN  rs2 value after forwarding.
stall_o  out  1  freezes the PC, IF/ID and ID/EX registers; inserts a bubble into EX/MEM.
busy_o  out  1  state is not IDLE.
result_o  out  XLEN  final result; valid only while result_valid_o = 1.
result_valid_o  out  1  one-cycle pulse; the EX result mux selects result_o.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, counter = 0, all datapath registers = 0.
  - stall_o = 0, busy_o = 0, result_o = 0, result_valid_o = 0.
- States: IDLE, RUN, DONE.
- stall_o = (IDLE & start_i & ~flush_i) | RUN. This is combinational so the start cycle itself stalls.
- IDLE -> RUN, when start_i & ~flush_i at cycle T:
  - Latch funct3, the operand magnitudes and the sign flags.
  - counter = 0.
  - Signedness per operand:
    - MULH: a and b signed.
    - MULHSU: a signed, b unsigned.
    - DIV/REM: both signed.
    - All others: unsigned.
- IDLE -> DONE directly (special cases, no RUN):
  - Divide by zero (op_b_i = 0):
    - DIV/DIVU result = all ones.
    - REM/REMU result = op_a_i.
  - Signed overflow (DIV/REM with op_a_i = 0x80000000 and op_b_i = 0xFFFFFFFF):
    - DIV result = 0x80000000.
    - REM result = 0.
  - Latency for special cases: 1 cycle (result_valid_o at T+1).
- RUN, one iteration per cycle:
  - Multiply: if multiplier bit 0 is set, add the multiplicand into the upper half of the 2*XLEN accumulator; then shift right.
  - Divide: shift the remainder:quotient pair left; trial-subtract the divisor magnitude; set the quotient bit if the result is non-negative.
  - counter increments each cycle; leave RUN when counter = XLEN-1.
  - RUN occupies T+1 .. T+XLEN.
- RUN -> DONE: apply sign fixup and write result_o.
  - Product negated if the signs differ (signed modes).
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DONE (T+XLEN+1 for iterative ops):
  - result_valid_o = 1, stall_o = 0.
  - The next state is always IDLE.
  - start_i in DONE is ignored, because the same instruction is leaving EX that cycle.
- flush_i:
  - In any state, the next state is IDLE with no result_valid_o pulse.
  - In IDLE with start_i, the start is not accepted and stall_o = 0.
  - In DONE, result_valid_o is still driven, but the pipeline discards it.
- result_o holds its last value outside DONE. Consumers must qualify it with result_valid_o.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs 0.
- Operand changes on op_a_i/op_b_i after T are ignored; only the latched copies are used.

Decomposition:
- Shared package (muldiv_pkg):
  - funct3 constants MUL..REMU.
  - MULDIV_FUNCT7 = 7'b0000001.
  - State encoding localparams IDLE/RUN/DONE.
  - XLEN default.
- Sub-module muldiv_dp: accumulator, shift/subtract step and sign fixup logic. The top level holds the FSM, counter and stall logic.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD):
  - stall_o high for 33 cycles.
  - result_valid_o at T+33.
  - result_o = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result_o = 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> result_o = 0x40000000.
- DIV -7 / 2 -> result_o = 0xFFFFFFFD (-3).
- REM -7 / 2 -> result_o = 0xFFFFFFFF (-1).
- DIVU 100 / 0 -> result_o = 0xFFFFFFFF at T+1.
- REMU 100 / 0 -> result_o = 100.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x80000000 at T+1, with no RUN cycles.
- DIVU 1000 / 7, flush_i at T+10:
  - state = IDLE at T+11, stall_o = 0, no valid pulse.
  - A new DIVU 1000 / 7 then gives result_o = 142.
- rst_n low at T+5 of a MUL: all outputs 0 asynchronously; after release, a MULHSU 0xFFFFFFFF x 2 gives result_o = 0xFFFFFFFF.
